// File: rtl/single_port_sram_8_bit.sv
// 256 x 8 single-port synchronous SRAM with registered read data.
// Flop-based storage so a synchronous reset can clear every word.
module single_port_sram_8_bit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic [ADDR_WIDTH-1:0] Address_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  input  logic                  Write_Enable,
  input  logic                  Read_Enable
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  do_write;
  logic                  do_read;

  // Write wins over a simultaneous read; the read is dropped, not forwarded.
  assign do_write = Write_Enable;
  assign do_read  = Read_Enable && !Write_Enable;

  always_comb begin
    data_out_d = data_out_q;
    if (do_read) begin
      data_out_d = mem_q[Address_In];
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_write) begin
      mem_q[Address_In] <= Data_In;
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign Data_Out = data_out_q;

endmodule

// File: tb/tb_single_port_sram_8_bit.sv
// Scoreboard bench for single_port_sram_8_bit: a reference array predicts
// read data, expectations are queued at issue and retired after the edge.
module tb_single_port_sram_8_bit;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [7:0] addr;
  logic [7:0] dout;
  logic       we;
  logic       re;

  logic [7:0] ref_mem [256];
  logic [7:0] exp_dout;
  logic [7:0] exp_q [$];
  int         n_checks;
  int         n_errors;

  single_port_sram_8_bit dut (
    .Clk_In       (clk),
    .Reset_In     (rst),
    .Data_In      (din),
    .Address_In   (addr),
    .Data_Out     (dout),
    .Write_Enable (we),
    .Read_Enable  (re)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Driver tasks: drive, take one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b0;
    we  = 1'b0;
    re  = 1'b0;
  endtask

  task automatic do_reset(input logic wr, input logic [7:0] a, input logic [7:0] d);
    rst = 1'b1; we = wr; re = 1'b0; addr = a; din = d;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    exp_dout = 8'h00;
    step();
    check("reset_dout", dout, exp_dout);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    rst = 1'b0; we = 1'b1; re = 1'b0; addr = a; din = d;
    ref_mem[a] = d;
    step();
    check("write_hold", dout, exp_dout);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a);
    rst = 1'b0; we = 1'b0; re = 1'b1; addr = a; din = 8'($urandom_range(0, 255));
    exp_q.push_back(ref_mem[a]);
    step();
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, dout, 8'hxx);
    end else begin
      exp_dout = exp_q.pop_front();
      check(tag, dout, exp_dout);
    end
  endtask

  task automatic do_both(input logic [7:0] a, input logic [7:0] d);
    rst = 1'b0; we = 1'b1; re = 1'b1; addr = a; din = d;
    ref_mem[a] = d;
    step();
    check("both_hold", dout, exp_dout);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0; we = 1'b0; re = 1'b0;
      addr = 8'($urandom_range(0, 255));
      din  = 8'($urandom_range(0, 255));
      step();
      check("idle_hold", dout, exp_dout);
    end
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rd;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; we = 1'b0; re = 1'b0; addr = 8'h00; din = 8'h00;
    exp_dout = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset clears array and output
    do_reset(1'b0, 8'h00, 8'h00);
    do_read("rst_rd_00", 8'h00);
    do_read("rst_rd_7f", 8'h7F);
    do_read("rst_rd_ff", 8'hFF);

    // Directed write-then-read
    do_write(8'h81, 8'h24);
    do_read("wr_rd_81", 8'h81);
    check("wr_rd_81_const", dout, 8'h24);

    // Random write-then-read pairs, back to back
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      do_write(ra, rd);
      do_read("rand_rd", ra);
    end

    // Overwrite: last write wins
    do_write(8'h55, 8'h01);
    do_write(8'h55, 8'hC7);
    do_read("last_wins", 8'h55);

    // Boundary addresses and neighbours
    do_reset(1'b0, 8'h00, 8'h00);
    do_write(8'h00, 8'hA5);
    do_write(8'hFF, 8'h5A);
    do_read("bnd_00", 8'h00);
    check("bnd_00_const", dout, 8'hA5);
    do_read("bnd_ff", 8'hFF);
    check("bnd_ff_const", dout, 8'h5A);
    do_read("bnd_01", 8'h01);
    do_read("bnd_fe", 8'hFE);

    // Simultaneous enables: write performed, output holds
    do_write(8'h20, 8'h11);
    do_read("sim_prior", 8'h20);
    do_both(8'h10, 8'h33);
    check("sim_hold_const", dout, 8'h11);
    do_read("sim_after", 8'h10);
    check("sim_after_const", dout, 8'h33);

    // Hold with both enables low
    do_write(8'h30, 8'h3C);
    do_read("hold_prior", 8'h30);
    do_idle(5);
    check("hold_const", dout, 8'h3C);
    do_read("hold_mem_30", 8'h30);
    do_read("hold_mem_10", 8'h10);
    do_read("hold_mem_00", 8'h00);

    // Reset mid-operation wins over a concurrent write
    do_write(8'h42, 8'hEE);
    do_reset(1'b1, 8'h43, 8'h99);
    do_read("midrst_42", 8'h42);
    do_read("midrst_43", 8'h43);
    check("midrst_const", dout, 8'h00);

    if (exp_q.size() != 0) check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
